cell_window_gen: RTL

CELL_WINDOW_GEN -- requirements
Module: cell_window_gen

---
 rtl/cell_window_gen_pkg.sv | 19 +
 rtl/cell_window_gen_if.sv | 33 +++
 rtl/cell_window_gen_line_buffer.sv | 25 ++
 rtl/cell_window_gen.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cell_window_gen_pkg.sv
// Shared types and cell-layout constants for the 3x3 window generator.
package cell_window_gen_pkg;

    localparam int PIX_W = 8;
    typedef logic [PIX_W-1:0] pixel_t;

    // A cell is a 3x3 window packed row-major, byte 0 = top-left.
    localparam int CELL_ROWS = 3;
    localparam int CELL_COLS = 3;
    localparam int CELL_CENTER = 4;
    localparam int cellDepth = CELL_ROWS * CELL_COLS * PIX_W;
    typedef logic [cellDepth-1:0] cell_t;

    // Byte index of window position (wr, wc), 0 = top/left.
    function automatic int cell_idx(input int wr, input int wc);
        return CELL_COLS * wr + wc;
    endfunction

endpackage

// File: rtl/cell_window_gen_if.sv
// Pixel-pair input stream and cell output stream of the window generator.
interface cell_window_gen_if
    import cell_window_gen_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64
) ();

    logic                          pix_valid;
    logic                          pix_ready;
    pixel_t                        pixA;
    pixel_t                        pixB;
    logic                          cell_valid;
    logic                          cell_ready;
    cell_t                         cellA;
    cell_t                         cellB;
    logic [$clog2(IMG_WIDTH)-1:0]  cell_x;
    logic [$clog2(IMG_HEIGHT)-1:0] cell_y;
    logic                          frame_done;

    // Pixel producer and cell consumer side.
    modport master (
        output pix_valid, pixA, pixB, cell_ready,
        input  pix_ready, cell_valid, cellA, cellB, cell_x, cell_y, frame_done
    );

    // Window generator side.
    modport slave (
        input  pix_valid, pixA, pixB, cell_ready,
        output pix_ready, cell_valid, cellA, cellB, cell_x, cell_y, frame_done
    );

endinterface

// File: rtl/cell_window_gen_line_buffer.sv
// One image row of delay: read returns the pixel stored one row earlier at addr.
module cell_line_buffer #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Combinational read sees the old entry before this cycle's overwrite.
    assign rdata = mem[addr];

    // Store the accepted pixel in place of the one just read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/cell_window_gen.sv
// Builds 3x3 windows of two images from a raster stream of pixel pairs.
module cell_window_gen
    import cell_window_gen_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64
) (
    input logic              clk,
    input logic              rst,
    cell_window_gen_if.slave bus
);

    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0] col_q, col_d, cell_x_q, cell_x_d;
    logic [YW-1:0] row_q, row_d, cell_y_q, cell_y_d;
    logic          pix_ready, accept, emit;
    logic          cell_valid_q, cell_valid_d;
    cell_t         cell_a_q, cell_a_d, cell_b_q, cell_b_d;
    pixel_t        a_up1, a_up2, b_up1, b_up2;
    pixel_t        col_a [CELL_ROWS];
    pixel_t        col_b [CELL_ROWS];
    // Columns col-2 and col-1 of each window row, relative to the incoming pixel.
    pixel_t        hist_a_q [CELL_ROWS][CELL_COLS-1];
    pixel_t        hist_a_d [CELL_ROWS][CELL_COLS-1];
    pixel_t        hist_b_q [CELL_ROWS][CELL_COLS-1];
    pixel_t        hist_b_d [CELL_ROWS][CELL_COLS-1];

    // Two chained row delays per image: up1 = row-1, up2 = row-2 at the current column.
    cell_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH($bits(pixel_t))) u_lb_a1 (
        .clk(clk), .we(accept), .addr(col_q), .wdata(bus.pixA), .rdata(a_up1)
    );
    cell_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH($bits(pixel_t))) u_lb_a2 (
        .clk(clk), .we(accept), .addr(col_q), .wdata(a_up1), .rdata(a_up2)
    );
    cell_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH($bits(pixel_t))) u_lb_b1 (
        .clk(clk), .we(accept), .addr(col_q), .wdata(bus.pixB), .rdata(b_up1)
    );
    cell_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH($bits(pixel_t))) u_lb_b2 (
        .clk(clk), .we(accept), .addr(col_q), .wdata(b_up1), .rdata(b_up2)
    );

    // Handshake and the freshly arriving window column (top to bottom).
    always_comb begin
        pix_ready = !cell_valid_q || bus.cell_ready;
        accept    = bus.pix_valid && pix_ready && !rst;
        emit      = accept && (row_q >= YW'(2)) && (col_q >= XW'(2));
        col_a[0]  = a_up2;
        col_a[1]  = a_up1;
        col_a[2]  = bus.pixA;
        col_b[0]  = b_up2;
        col_b[1]  = b_up1;
        col_b[2]  = bus.pixB;
    end

    // Raster position, window shift and output cell next state.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hist_a_d     = hist_a_q;
        hist_b_d     = hist_b_q;
        cell_a_d     = cell_a_q;
        cell_b_d     = cell_b_q;
        cell_x_d     = cell_x_q;
        cell_y_d     = cell_y_q;
        cell_valid_d = cell_valid_q;
        if (accept) begin
            if (col_q == XW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == YW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int r = 0; r < CELL_ROWS; r++) begin
                hist_a_d[r][0] = hist_a_q[r][1];
                hist_a_d[r][1] = col_a[r];
                hist_b_d[r][0] = hist_b_q[r][1];
                hist_b_d[r][1] = col_b[r];
            end
        end
        if (emit) begin
            for (int r = 0; r < CELL_ROWS; r++) begin
                for (int c = 0; c < CELL_COLS - 1; c++) begin
                    cell_a_d[PIX_W*cell_idx(r, c) +: PIX_W] = hist_a_q[r][c];
                    cell_b_d[PIX_W*cell_idx(r, c) +: PIX_W] = hist_b_q[r][c];
                end
                cell_a_d[PIX_W*cell_idx(r, CELL_COLS-1) +: PIX_W] = col_a[r];
                cell_b_d[PIX_W*cell_idx(r, CELL_COLS-1) +: PIX_W] = col_b[r];
            end
            cell_x_d     = col_q - 1'b1;
            cell_y_d     = row_q - 1'b1;
            cell_valid_d = 1'b1;
        end else if (bus.cell_ready) begin
            cell_valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            cell_valid_q <= 1'b0;
            cell_a_q     <= '0;
            cell_b_q     <= '0;
            cell_x_q     <= '0;
            cell_y_q     <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            cell_valid_q <= cell_valid_d;
            cell_a_q     <= cell_a_d;
            cell_b_q     <= cell_b_d;
            cell_x_q     <= cell_x_d;
            cell_y_q     <= cell_y_d;
        end
    end

    // Window history only matters once refilled by two pixels of a row, so no reset.
    always_ff @(posedge clk) begin
        hist_a_q <= hist_a_d;
        hist_b_q <= hist_b_d;
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.cell_valid = cell_valid_q;
    assign bus.cellA      = cell_a_q;
    assign bus.cellB      = cell_b_q;
    assign bus.cell_x     = cell_x_q;
    assign bus.cell_y     = cell_y_q;
    // Last cell of the frame leaving this cycle.
    assign bus.frame_done = cell_valid_q && bus.cell_ready && !rst &&
                            (cell_x_q == XW'(IMG_WIDTH - 2)) &&
                            (cell_y_q == YW'(IMG_HEIGHT - 2));

endmodule
